nanosoc_axi_stream_8to32_pack: RTL

Synthesizable 8-to-32-bit AXI-Stream packer that consumes the byte stream produced by the 8-bit TX playback/UART-style sources and presents little-endian 32-bit beats to wide consumers (memory loaders, FIFOs). Partial words are flushed on an end-of-transmission byte (framing, with `tlast`) or after a programmable idle timeout. Sits directly downstream of the 8-bit stream source in the nanosoc trace/verification path and is also usable in RTL.

---
 rtl/nanosoc_axi_stream_8to32_pack.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/nanosoc_axi_stream_8to32_pack.sv
// -----------------------------------------------------------------------------
// nanosoc_axi_stream_8to32_pack
//
// Packs an 8-bit AXI-Stream byte source into little-endian 32-bit beats.
// Byte 0 of a word lands in txd32_data[7:0].
//
// A partial word is sent in two cases:
//   - an end-of-transmission byte arrives. The word is marked with tlast and
//     the EOT byte itself is dropped.
//   - the input stays idle for FLUSH_TIMEOUT cycles. Here tlast stays low.
//
// Configuration:
//   NANOSOC_AXIS_PACK_EOT_EN  When defined, EOT_CHAR ends a frame.
//                             When undefined, EOT_CHAR is ordinary data,
//                             txd32_last is always 0 and eot_seen is always 0.
//
// Parameters:
//   EOT_CHAR       byte value recognised as end-of-transmission
//   FLUSH_TIMEOUT  idle cycles before a partial word is flushed
//                  (0 disables, legal range 0..65535)
//
// Ports:
//   aclk         clock, all state updates on the rising edge
//   areset       synchronous, active-high reset
//   rxd8_valid   byte valid from upstream
//   rxd8_data    byte data
//   rxd8_ready   byte accepted when rxd8_valid & rxd8_ready
//   txd32_valid  packed word valid
//   txd32_data   packed word, little-endian
//   txd32_keep   byte lanes that hold real data
//   txd32_last   final beat of a frame (EOT-terminated)
//   txd32_ready  downstream accept
//   eot_seen     sticky flag, set once an EOT byte has been accepted
// -----------------------------------------------------------------------------
module nanosoc_axi_stream_8to32_pack #(
    parameter logic [7:0]  EOT_CHAR      = 8'h04,
    parameter int unsigned FLUSH_TIMEOUT = 32'd0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        rxd8_valid,
    input  logic [7:0]  rxd8_data,
    output logic        rxd8_ready,
    output logic        txd32_valid,
    output logic [31:0] txd32_data,
    output logic [3:0]  txd32_keep,
    output logic        txd32_last,
    input  logic        txd32_ready,
    output logic        eot_seen
);

    localparam logic [15:0] TIMEOUT_C    = 16'(FLUSH_TIMEOUT);
    localparam bit          TIMEOUT_EN_C = (FLUSH_TIMEOUT != 32'd0);

    // Returns the keep mask for a partial word holding n bytes in lanes 0..n-1.
    function automatic logic [3:0] keep_for_count(input logic [1:0] n);
        logic [3:0] k;
        case (n)
            2'd0:    k = 4'b0000;
            2'd1:    k = 4'b0001;
            2'd2:    k = 4'b0011;
            2'd3:    k = 4'b0111;
            default: k = 4'b0000;
        endcase
        return k;
    endfunction

    // Expands a 4-bit keep into a 32-bit byte-lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    logic [23:0] acc_r;
    logic [1:0]  cnt_r;
    logic [15:0] idle_r;
    logic        valid_r;
    logic [31:0] data_r;
    logic [3:0]  keep_r;
    logic        last_r;
    logic        eot_seen_r;

    logic        out_free_s;
    logic        accept_s;
    logic        is_eot_s;
    logic        accept_eot_s;
    logic        accept_data_s;
    logic        word_full_s;
    logic        flush_s;
    logic [3:0]  partial_keep_s;
    logic [31:0] partial_data_s;

`ifdef NANOSOC_AXIS_PACK_EOT_EN
    assign is_eot_s = (rxd8_data == EOT_CHAR);
`else
    // Without EOT support, the EOT character is just data.
    logic unused_eot_char_s;
    assign unused_eot_char_s = ^EOT_CHAR;
    assign is_eot_s          = 1'b0;
`endif

    // The output register is free when it is empty or is being drained this cycle.
    always_comb begin
        out_free_s     = !valid_r || txd32_ready;
        accept_s       = rxd8_valid && out_free_s;
        accept_eot_s   = accept_s && is_eot_s;
        accept_data_s  = accept_s && !is_eot_s;
        word_full_s    = accept_data_s && (cnt_r == 2'd3);
        // An accepted byte always wins over an expiring timeout.
        flush_s        = TIMEOUT_EN_C && (cnt_r != 2'd0) && !accept_s
                         && (idle_r == TIMEOUT_C) && out_free_s;
        partial_keep_s = keep_for_count(cnt_r);
        partial_data_s = {8'h00, acc_r} & lane_mask(partial_keep_s);
    end

    assign rxd8_ready  = !valid_r || txd32_ready;
    assign txd32_valid = valid_r;
    assign txd32_data  = data_r;
    assign txd32_keep  = keep_r;
    assign txd32_last  = last_r;
    assign eot_seen    = eot_seen_r;

    // Accumulator lanes and lane count for the word being assembled.
    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_r <= 24'h000000;
            cnt_r <= 2'd0;
        end else if (accept_data_s) begin
            case (cnt_r)
                2'd0:    acc_r[7:0]   <= rxd8_data;
                2'd1:    acc_r[15:8]  <= rxd8_data;
                2'd2:    acc_r[23:16] <= rxd8_data;
                default: acc_r        <= acc_r;
            endcase
            cnt_r <= cnt_r + 2'd1;
        end else if (accept_eot_s || flush_s) begin
            cnt_r <= 2'd0;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Idle counter: runs only while a partial word is waiting.
    // It holds at the timeout value until the output register frees up.
    always_ff @(posedge aclk) begin
        if (areset) begin
            idle_r <= 16'h0000;
        end else if (accept_s || (cnt_r == 2'd0) || !TIMEOUT_EN_C || flush_s) begin
            idle_r <= 16'h0000;
        end else if ((idle_r == TIMEOUT_C) || (idle_r == 16'hFFFF)) begin
            idle_r <= idle_r;
        end else begin
            idle_r <= idle_r + 16'h0001;
        end
    end

    // Output beat register: a reload takes priority over draining.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_r <= 1'b0;
            data_r  <= 32'h0000_0000;
            keep_r  <= 4'b0000;
            last_r  <= 1'b0;
        end else if (word_full_s) begin
            valid_r <= 1'b1;
            data_r  <= {rxd8_data, acc_r};
            keep_r  <= 4'b1111;
            last_r  <= 1'b0;
        end else if (accept_eot_s) begin
            valid_r <= 1'b1;
            data_r  <= partial_data_s;
            keep_r  <= partial_keep_s;
            last_r  <= 1'b1;
        end else if (flush_s) begin
            valid_r <= 1'b1;
            data_r  <= partial_data_s;
            keep_r  <= partial_keep_s;
            last_r  <= 1'b0;
        end else if (valid_r && txd32_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Sticky end-of-transmission flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            eot_seen_r <= 1'b0;
        end else if (accept_eot_s) begin
            eot_seen_r <= 1'b1;
        end else begin
            eot_seen_r <= eot_seen_r;
        end
    end

endmodule
